if_prefetch_buffer: RTL and testbench



---
 rtl/if_prefetch_buffer_pkg.sv | 19 +
 rtl/if_prefetch_buffer_if.sv | 24 ++
 rtl/if_prefetch_buffer_fifo.sv | 64 ++++++
 rtl/if_prefetch_buffer.sv | 127 ++++++++++++
 tb/tb_if_prefetch_buffer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_prefetch_buffer_pkg.sv
// Shared fetch-side definitions: NOP encoding, default reset PC, FSM state
// names and the {pc, instr} entry stored in the prefetch FIFO.
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry;

endpackage

// File: rtl/if_prefetch_buffer_if.sv
// Instruction-memory request/response bus. The fetch unit is the master;
// the memory (or its model) is the slave.
interface if_prefetch_buffer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_prefetch_buffer_fifo.sv
// Generic DEPTH-entry FIFO of {pc, instr} pairs with first-word fall-through
// head. Clear wins over push and pop; push on full is only accepted when a
// pop frees a slot in the same cycle.
module prefetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  fetch_entry                 din,
    output fetch_entry                 head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry     mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; an entry is only ever read after it has been written.
    // NOTE: the storage array has no reset, so it maps onto plain RAM/regfile cells.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch front end: issues sequential fetches to a variable-latency
// memory (one request outstanding), buffers {PC, instruction} pairs in a small
// FIFO and presents the head to IF/ID. A taken branch flushes the FIFO and
// either retargets the in-flight request (ack in the same cycle) or marks the
// pending response for discard.
module if_prefetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       PCSrc,
    input  logic [31:0]                PC_Branch,
    input  logic                       IF_ID_write,
    if_prefetch_buffer_if.master       bus,
    output logic [31:0]                PC_IF,
    output logic [31:0]                INSTRUCTION_IF,
    output logic                       instr_valid,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_WAIT    = WAIT;
    localparam logic [1:0] ST_DISCARD = DISCARD;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] next_addr;
    logic        pop;
    logic        push;
    logic        fifo_empty;
    logic        fifo_full;
    logic        can_issue;
    logic        can_stay;
    int          occ_after_pop;
    fetch_entry  push_entry;
    fetch_entry  head_entry;

    // Flush beats pop and push; a response is only kept when it answers a live request.
    assign pop  = instr_valid & IF_ID_write & ~PCSrc;
    assign push = (state == ST_WAIT) & bus.imem_ack & ~PCSrc;

    // Issue only when this cycle's pop leaves room; stay back-to-back only when
    // the push and pop together still leave room for the next response.
    assign occ_after_pop = int'(fifo_count) - int'(pop);
    assign can_issue     = ~fifo_full | pop;
    assign can_stay      = (occ_after_pop + 1) < DEPTH;

    assign next_addr  = bus.imem_addr + 32'd4;
    assign push_entry = '{pc: bus.imem_addr, instr: bus.imem_rdata};

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (PCSrc),
        .din   (push_entry),
        .head  (head_entry),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign instr_valid    = ~fifo_empty;
    assign PC_IF          = instr_valid ? head_entry.pc    : 32'h0000_0000;
    assign INSTRUCTION_IF = instr_valid ? head_entry.instr : NOP_INSTR;

    // Fetch sequencer: registered request/address plus the next sequential PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
            fetch_pc      <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (PCSrc) begin
                        fetch_pc <= PC_Branch;
                    end else if (can_issue) begin
                        bus.imem_req  <= 1'b1;
                        bus.imem_addr <= fetch_pc;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (PCSrc && bus.imem_ack) begin
                        // Response already here: drop it and retarget immediately.
                        bus.imem_addr <= PC_Branch;
                        fetch_pc      <= PC_Branch;
                    end else if (PCSrc) begin
                        // Old request still pending; its response must be thrown away.
                        fetch_pc <= PC_Branch;
                        state    <= ST_DISCARD;
                    end else if (bus.imem_ack) begin
                        fetch_pc <= next_addr;
                        if (can_stay) begin
                            bus.imem_addr <= next_addr;
                        end else begin
                            bus.imem_req <= 1'b0;
                            state        <= ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (bus.imem_ack) begin
                        bus.imem_addr <= PCSrc ? PC_Branch : fetch_pc;
                        fetch_pc      <= PCSrc ? PC_Branch : fetch_pc;
                        state         <= ST_WAIT;
                    end else if (PCSrc) begin
                        fetch_pc <= PC_Branch;
                    end
                end
                default: begin
                    bus.imem_req <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Self-checking bench for if_prefetch_buffer: a variable-latency memory model,
// a queue-based reference of the fetch buffer, an in-order consumed-stream
// check, directed scenarios and a randomized phase.
module tb_if_prefetch_buffer;
    import riscv_fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc;
    logic [31:0] PC_Branch;
    logic        IF_ID_write;
    logic [31:0] PC_IF;
    logic [31:0] INSTRUCTION_IF;
    logic        instr_valid;
    logic [2:0]  fifo_count;

    if_prefetch_buffer_if bus ();

    if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .PCSrc          (PCSrc),
        .PC_Branch      (PC_Branch),
        .IF_ID_write    (IF_ID_write),
        .bus            (bus),
        .PC_IF          (PC_IF),
        .INSTRUCTION_IF (INSTRUCTION_IF),
        .instr_valid    (instr_valid),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    // Memory model state
    int wait_cnt;
    int cur_lat;
    int lat_min;
    int lat_max;

    // Reference model: contents of the buffer, the outstanding request,
    // whether its response is stale, and the next sequential fetch address.
    fetch_entry  mq[$];
    bit          m_req;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_fetch;
    logic [31:0] exp_seq;   // next PC the consumer should receive

    task automatic set_latency(input int lo, input int hi);
        lat_min = lo;
        lat_max = hi;
        cur_lat = $urandom_range(hi, lo);
    endtask

    task automatic model_reset();
        mq.delete();
        m_req    = 1'b0;
        m_drop   = 1'b0;
        m_addr   = RPC;
        m_fetch  = RPC;
        exp_seq  = RPC;
        wait_cnt = 0;
    endtask

    // Drives this cycle's response from the request currently on the bus.
    task automatic mem_drive();
        if (bus.imem_req === 1'b1) begin
            if (wait_cnt >= cur_lat - 1) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
                wait_cnt       = 0;
                cur_lat        = $urandom_range(lat_max, lat_min);
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'hDEAD_BEEF;
            wait_cnt       = 0;
        end
    endtask

    // Advances the reference by one clock using only bench-driven inputs.
    task automatic model_step();
        bit         pop;
        bit         push;
        fetch_entry pe;
        pop  = (mq.size() > 0) && IF_ID_write && !PCSrc;
        push = 1'b0;
        pe   = '{pc: 32'h0, instr: 32'h0};
        if (!m_req) begin
            if (PCSrc) m_fetch = PC_Branch;
            else if (mq.size() - int'(pop) < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_fetch;
            end
        end else if (bus.imem_ack) begin
            if (m_drop) begin
                m_drop = 1'b0;
                if (PCSrc) m_fetch = PC_Branch;
                m_addr = m_fetch;
            end else if (PCSrc) begin
                m_addr  = PC_Branch;
                m_fetch = PC_Branch;
            end else begin
                push    = 1'b1;
                pe      = '{pc: m_addr, instr: mem_word(m_addr)};
                m_fetch = m_addr + 32'd4;
                if (mq.size() - int'(pop) + 1 < DEPTH) m_addr = m_addr + 32'd4;
                else m_req = 1'b0;
            end
        end else if (PCSrc) begin
            m_fetch = PC_Branch;
            m_drop  = 1'b1;
        end
        if (PCSrc) mq.delete();
        if (pop)   void'(mq.pop_front());
        if (push)  mq.push_back(pe);
    endtask

    task automatic compare_all();
        check("valid", 32'(instr_valid), 32'(mq.size() > 0));
        check("count", 32'(fifo_count), 32'(mq.size()));
        check("pc_if", PC_IF, (mq.size() > 0) ? mq[0].pc : 32'h0);
        check("instr_if", INSTRUCTION_IF, (mq.size() > 0) ? mq[0].instr : NOP_INSTR);
        check("req", 32'(bus.imem_req), 32'(m_req));
        check("addr", bus.imem_addr, m_addr);
    endtask

    // One clock: respond, check any consumed entry, clock, model, compare.
    task automatic cycle();
        mem_drive();
        if ((mq.size() > 0) && IF_ID_write && !PCSrc) begin
            check("stream_pc", PC_IF, exp_seq);
            check("stream_instr", INSTRUCTION_IF, mem_word(exp_seq));
            exp_seq = exp_seq + 32'd4;
        end
        if (PCSrc) exp_seq = PC_Branch;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic reset_dut();
        reset        = 1'b1;
        PCSrc        = 1'b0;
        bus.imem_ack = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit found;
        reset          = 1'b1;
        PCSrc          = 1'b0;
        PC_Branch      = 32'h0;
        IF_ID_write    = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        set_latency(1, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_pc_if", PC_IF, 32'h0);
        check("rst_instr", INSTRUCTION_IF, NOP_INSTR);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, RPC);
        reset = 1'b0;

        // Zero-wait streaming: one ack per cycle, one pop per cycle
        repeat (12) cycle();
        check("stream_head", PC_IF, 32'd40);
        check("stream_addr", bus.imem_addr, 32'd44);
        check("stream_valid", 32'(instr_valid), 32'd1);

        // Consumer stall from reset: buffer fills to DEPTH and fetch stops
        reset_dut();
        IF_ID_write = 1'b0;
        repeat (10) cycle();
        check("stall_count", 32'(fifo_count), 32'd4);
        check("stall_req", 32'(bus.imem_req), 32'd0);
        check("stall_pc_if", PC_IF, 32'h0);
        IF_ID_write = 1'b1;
        cycle();
        check("resume_req", 32'(bus.imem_req), 32'd1);
        check("resume_addr", bus.imem_addr, 32'd16);
        check("resume_pc_if", PC_IF, 32'd4);
        // Ack and pop together at the highest occupancy a live request can see
        cycle();
        check("pushpop_count", 32'(fifo_count), 32'd3);
        check("pushpop_head", PC_IF, 32'd8);
        repeat (3) cycle();

        // 3-cycle memory, branch while the request for 0x20 is pending
        reset_dut();
        set_latency(3, 3);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            cycle();
            if (bus.imem_req === 1'b1 && bus.imem_addr === 32'h20) found = 1'b1;
        end
        check("reach_0x20", 32'(found), 32'd1);
        PCSrc     = 1'b1;
        PC_Branch = 32'h100;
        cycle();
        PCSrc = 1'b0;
        check("flush_valid", 32'(instr_valid), 32'd0);
        check("flush_count", 32'(fifo_count), 32'd0);
        check("flush_hold_addr", bus.imem_addr, 32'h20);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (instr_valid === 1'b1) found = 1'b1;
        end
        check("redirect_seen", 32'(found), 32'd1);
        check("redirect_pc", PC_IF, 32'h100);

        // Branch in the same cycle as a response
        set_latency(1, 1);
        repeat (4) cycle();
        check("pre_ackflush_req", 32'(bus.imem_req), 32'd1);
        PCSrc     = 1'b1;
        PC_Branch = 32'h40;
        cycle();
        PCSrc = 1'b0;
        check("ackflush_addr", bus.imem_addr, 32'h40);
        check("ackflush_req", 32'(bus.imem_req), 32'd1);
        check("ackflush_valid", 32'(instr_valid), 32'd0);
        cycle();
        check("ackflush_head", PC_IF, 32'h40);

        // Address wrap at the top of the 32-bit space
        PCSrc     = 1'b1;
        PC_Branch = 32'hFFFF_FFF8;
        cycle();
        PCSrc = 1'b0;
        repeat (6) cycle();

        // Randomized traffic: stalls, branches and latencies 1..4
        set_latency(1, 4);
        repeat (2000) begin
            IF_ID_write = ($urandom_range(9, 0) < 7);
            PCSrc       = ($urandom_range(19, 0) == 0);
            PC_Branch   = $urandom() & 32'hFFFF_FFFC;
            cycle();
        end
        PCSrc       = 1'b0;
        IF_ID_write = 1'b1;

        // Asynchronous reset while a request is pending
        set_latency(3, 3);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (bus.imem_req === 1'b1 && instr_valid === 1'b1 && wait_cnt == 0) found = 1'b1;
        end
        check("pre_async_busy", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_req", 32'(bus.imem_req), 32'd0);
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_count", 32'(fifo_count), 32'd0);
        bus.imem_ack = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle();
        check("post_rst_req", 32'(bus.imem_req), 32'd1);
        check("post_rst_addr", bus.imem_addr, RPC);
        repeat (8) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
